alu_multicycle: RTL and testbench

Execution stage that consumes the 4-bit ALU operation code produced by the ALU control decoder and computes the datapath result. Logic and arithmetic operations finish in one cycle. Shifts run through a serial shifter at one bit per cycle. A start/busy/done handshake lets the control path stall while a shift is in progress.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_multicycle_if.sv | 26 ++
 rtl/alu_serial_shifter.sv | 43 ++++
 rtl/alu_multicycle.sv | 113 +++++++++++
 tb/tb_alu_multicycle.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes and execution-stage state encoding
package alu_pkg;

    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - start/busy/done request and result bundle of the execution stage
interface alu_multicycle_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
);
    logic                   start_i;
    logic [3:0]             alu_operation_i;
    logic [DATA_WIDTH-1:0]  a_i;
    logic [DATA_WIDTH-1:0]  b_i;
    logic [SHAMT_WIDTH-1:0] shamt_i;
    logic                   busy_o;
    logic                   done_o;
    logic [DATA_WIDTH-1:0]  result_o;
    logic                   zero_o;
    logic                   illegal_o;

    modport master (
        output start_i, alu_operation_i, a_i, b_i, shamt_i,
        input  busy_o, done_o, result_o, zero_o, illegal_o
    );

    modport slave (
        input  start_i, alu_operation_i, a_i, b_i, shamt_i,
        output busy_o, done_o, result_o, zero_o, illegal_o
    );
endinterface

// File: rtl/alu_serial_shifter.sv
// rtl/alu_serial_shifter.sv - one-bit-per-cycle shift register with down-counter
module alu_serial_shifter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   dir,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [SHAMT_WIDTH-1:0] amount,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   last
);
    logic [DATA_WIDTH-1:0]  r_data;
    logic [SHAMT_WIDTH-1:0] r_cnt;
    logic                   r_dir;
    logic [DATA_WIDTH-1:0]  w_next;

    // dir = 1 shifts right with zero fill; direction is latched at load
    assign w_next = r_dir ? (r_data >> 1) : (r_data << 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_dir  <= 1'b0;
        end else if (load) begin
            r_data <= data;
            r_cnt  <= amount;
            r_dir  <= dir;
        end else if (r_cnt != '0) begin
            r_data <= w_next;
            r_cnt  <= r_cnt - SHAMT_WIDTH'(1);
        end
    end

    // data_out is the value the register takes on this edge, so the final
    // shift result can be captured on the same edge that clears the counter
    assign data_out = w_next;
    assign last     = (r_cnt == SHAMT_WIDTH'(1));

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - execution stage with single-cycle logic/arith ops and serial shifts
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic               clk,
    input  logic               reset,
    alu_multicycle_if.slave    bus
);
    alu_state_t            r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic                  r_illegal;

    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_illegal;
    logic                  w_load;
    logic                  w_dir;
    logic [DATA_WIDTH-1:0] w_sh_data;
    logic                  w_sh_last;

    // shift codes evaluate to b here; that is the answer only for shamt 0
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (bus.alu_operation_i)
            ALU_OR:           w_result = bus.a_i | bus.b_i;
            ALU_ADD:          w_result = bus.a_i + bus.b_i;
            ALU_SUB:          w_result = bus.a_i - bus.b_i;
            ALU_LUI:          w_result = {bus.b_i[15:0], {(DATA_WIDTH-16){1'b0}}};
            ALU_AND:          w_result = bus.a_i & bus.b_i;
            ALU_NOR:          w_result = ~(bus.a_i | bus.b_i);
            ALU_SLL, ALU_SRL: w_result = bus.b_i;
            default:          w_illegal = 1'b1;
        endcase
    end

    assign w_load = (r_state == ST_IDLE) && bus.start_i
                    && is_shift(bus.alu_operation_i) && (bus.shamt_i != '0);
    assign w_dir  = (bus.alu_operation_i == ALU_SRL);

    alu_serial_shifter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .dir      (w_dir),
        .data     (bus.b_i),
        .amount   (bus.shamt_i),
        .data_out (w_sh_data),
        .last     (w_sh_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start_i) begin
                        r_busy    <= 1'b1;
                        r_illegal <= w_illegal;
                        if (w_load) begin
                            r_state <= ST_SHIFT;
                        end else begin
                            r_result <= w_result;
                            r_zero   <= (w_result == '0);
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_sh_last) begin
                        r_result <= w_sh_data;
                        r_zero   <= (w_sh_data == '0);
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o    = r_busy;
    assign bus.done_o    = r_done;
    assign bus.result_o  = r_result;
    assign bus.zero_o    = r_zero;
    assign bus.illegal_o = r_illegal;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed self-checking bench for alu_multicycle
module tb_alu_multicycle;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    alu_multicycle_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus();

    alu_multicycle #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        @(negedge clk);
        bus.start_i         = 1'b1;
        bus.alu_operation_i = op;
        bus.a_i             = a;
        bus.b_i             = b;
        bus.shamt_i         = sh;
        @(negedge clk);
        bus.start_i         = 1'b0;
        bus.alu_operation_i = ALU_ADD;
        bus.a_i             = 32'hDEAD_BEEF;
        bus.b_i             = 32'h5A5A_A5A5;
        bus.shamt_i         = 5'd17;
    endtask

    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 1;
        busy_cyc = 0;
        while (bus.done_o !== 1'b1 && lat < 64) begin
            if (bus.busy_o === 1'b1) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        if (bus.busy_o === 1'b1) busy_cyc++;
    endtask

    task automatic test_reset;
        reset               = 1'b0;
        bus.start_i         = 1'b0;
        bus.alu_operation_i = 4'b0000;
        bus.a_i             = '0;
        bus.b_i             = '0;
        bus.shamt_i         = '0;
        repeat (2) @(negedge clk);
        total++; if (bus.busy_o !== 1'b0)    begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        total++; if (bus.done_o !== 1'b0)    begin bad++; $display("FAIL reset_done got %b want 0", bus.done_o); end
        total++; if (bus.result_o !== 32'h0) begin bad++; $display("FAIL reset_result got %h want 0", bus.result_o); end
        total++; if (bus.zero_o !== 1'b1)    begin bad++; $display("FAIL reset_zero got %b want 1", bus.zero_o); end
        total++; if (bus.illegal_o !== 1'b0) begin bad++; $display("FAIL reset_illegal got %b want 0", bus.illegal_o); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.busy_o !== 1'b0)    begin bad++; $display("FAIL idle_busy got %b want 0", bus.busy_o); end
    endtask

    task automatic test_logic_arith;
        logic [3:0]  ops  [8];
        logic [31:0] av   [8];
        logic [31:0] bv   [8];
        logic [31:0] expv [8];
        int lat, bc;
        ops  = '{ALU_ADD, ALU_SUB, ALU_NOR, ALU_LUI, ALU_OR, ALU_AND, ALU_ADD, ALU_LUI};
        av   = '{32'hFFFF_FFFF, 32'd5, 32'h0, 32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_F0F0, 32'd3, 32'h0};
        bv   = '{32'd1, 32'd7, 32'h0, 32'h0000_1234, 32'h0000_000F, 32'h0000_FF00, 32'd4, 32'hFFFF_ABCD};
        expv = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h1234_0000, 32'h0000_00FF, 32'h0000_F000, 32'd7, 32'hABCD_0000};
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], av[i], bv[i], 5'd9);
            wait_done(lat, bc);
            total++; if (lat !== 1)                  begin bad++; $display("FAIL op%0d_latency got %0d want 1", i, lat); end
            total++; if (bus.result_o !== expv[i])   begin bad++; $display("FAIL op%0d_result got %h want %h", i, bus.result_o, expv[i]); end
            total++; if (bus.zero_o !== (expv[i] == 32'h0)) begin bad++; $display("FAIL op%0d_zero got %b want %b", i, bus.zero_o, expv[i] == 32'h0); end
            total++; if (bus.illegal_o !== 1'b0)     begin bad++; $display("FAIL op%0d_illegal got %b want 0", i, bus.illegal_o); end
            @(negedge clk);
            total++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                bad++; $display("FAIL op%0d_after_done done=%b busy=%b want 0 0", i, bus.done_o, bus.busy_o);
            end
        end
    endtask

    task automatic test_shift;
        logic [3:0]  ops  [4];
        logic [31:0] bv   [4];
        logic [4:0]  shv  [4];
        logic [31:0] expv [4];
        int          latv [4];
        int lat, bc;
        ops  = '{ALU_SLL, ALU_SRL, ALU_SLL, ALU_SRL};
        bv   = '{32'h0000_0001, 32'h8000_0000, 32'h0000_1234, 32'hA5A5_0000};
        shv  = '{5'd31, 5'd4, 5'd0, 5'd1};
        expv = '{32'h8000_0000, 32'h0800_0000, 32'h0000_1234, 32'h52D2_8000};
        latv = '{32, 5, 1, 2};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], 32'hFFFF_FFFF, bv[i], shv[i]);
            wait_done(lat, bc);
            total++; if (lat !== latv[i])           begin bad++; $display("FAIL sh%0d_latency got %0d want %0d", i, lat, latv[i]); end
            total++; if (bc !== latv[i])            begin bad++; $display("FAIL sh%0d_busy_cycles got %0d want %0d", i, bc, latv[i]); end
            total++; if (bus.result_o !== expv[i])  begin bad++; $display("FAIL sh%0d_result got %h want %h", i, bus.result_o, expv[i]); end
            total++; if (bus.zero_o !== 1'b0 || bus.illegal_o !== 1'b0) begin
                bad++; $display("FAIL sh%0d_flags zero=%b illegal=%b want 0 0", i, bus.zero_o, bus.illegal_o);
            end
            @(negedge clk);
            total++; if (bus.busy_o !== 1'b0)       begin bad++; $display("FAIL sh%0d_busy_after got %b want 0", i, bus.busy_o); end
        end
    endtask

    task automatic test_illegal;
        logic [3:0] ops [3];
        int lat, bc;
        ops = '{4'b1001, 4'b0000, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
            wait_done(lat, bc);
            total++; if (lat !== 1)               begin bad++; $display("FAIL ill%0d_latency got %0d want 1", i, lat); end
            total++; if (bus.result_o !== 32'h0)  begin bad++; $display("FAIL ill%0d_result got %h want 0", i, bus.result_o); end
            total++; if (bus.illegal_o !== 1'b1)  begin bad++; $display("FAIL ill%0d_illegal got %b want 1", i, bus.illegal_o); end
            total++; if (bus.zero_o !== 1'b1)     begin bad++; $display("FAIL ill%0d_zero got %b want 1", i, bus.zero_o); end
        end
    endtask

    task automatic test_back_to_back;
        int          dcnt = 0;
        int          dpos = 0;
        logic [31:0] dres = '0;
        @(negedge clk);
        bus.start_i         = 1'b1;
        bus.alu_operation_i = ALU_SRL;
        bus.a_i             = 32'h0;
        bus.b_i             = 32'hF000_0000;
        bus.shamt_i         = 5'd8;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                dcnt++;
                dpos = i;
                dres = bus.result_o;
            end
            if (i < 9) begin
                bus.alu_operation_i = (i % 2 == 1) ? ALU_ADD : ALU_SLL;
                bus.a_i             = 32'(i);
                bus.b_i             = 32'h1111_1111 * 32'(i);
                bus.shamt_i         = 5'(i + 2);
            end else begin
                bus.alu_operation_i = ALU_ADD;
                bus.a_i             = 32'd2;
                bus.b_i             = 32'd3;
                bus.shamt_i         = 5'd0;
            end
        end
        total++; if (dcnt !== 1)              begin bad++; $display("FAIL b2b_done_count got %0d want 1", dcnt); end
        total++; if (dpos !== 9)              begin bad++; $display("FAIL b2b_done_cycle got %0d want 9", dpos); end
        total++; if (dres !== 32'h00F0_0000)  begin bad++; $display("FAIL b2b_result got %h want 00f00000", dres); end
        @(negedge clk);
        total++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            bad++; $display("FAIL b2b_gap busy=%b done=%b want 0 0", bus.busy_o, bus.done_o);
        end
        @(negedge clk);
        total++; if (bus.done_o !== 1'b1)     begin bad++; $display("FAIL b2b_next_done got %b want 1", bus.done_o); end
        total++; if (bus.result_o !== 32'd5)  begin bad++; $display("FAIL b2b_next_result got %h want 5", bus.result_o); end
        bus.start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift;
        int lat, bc;
        int dcnt = 0;
        issue(ALU_ADD, 32'd2, 32'd3, 5'd0);
        wait_done(lat, bc);
        issue(ALU_SLL, 32'h0, 32'h1, 5'd20);
        repeat (4) @(negedge clk);
        total++; if (bus.busy_o !== 1'b1)     begin bad++; $display("FAIL mid_busy got %b want 1", bus.busy_o); end
        #2 reset = 1'b0;
        #1;
        total++; if (bus.busy_o !== 1'b0)     begin bad++; $display("FAIL mid_rst_busy got %b want 0", bus.busy_o); end
        total++; if (bus.done_o !== 1'b0)     begin bad++; $display("FAIL mid_rst_done got %b want 0", bus.done_o); end
        total++; if (bus.result_o !== 32'h0)  begin bad++; $display("FAIL mid_rst_result got %h want 0", bus.result_o); end
        total++; if (bus.zero_o !== 1'b1)     begin bad++; $display("FAIL mid_rst_zero got %b want 1", bus.zero_o); end
        total++; if (bus.illegal_o !== 1'b0)  begin bad++; $display("FAIL mid_rst_illegal got %b want 0", bus.illegal_o); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) dcnt++;
        end
        total++; if (dcnt !== 0)              begin bad++; $display("FAIL mid_no_done got %0d active cycles want 0", dcnt); end
        issue(ALU_ADD, 32'd7, 32'd8, 5'd0);
        wait_done(lat, bc);
        total++; if (lat !== 1)               begin bad++; $display("FAIL mid_add_latency got %0d want 1", lat); end
        total++; if (bus.result_o !== 32'd15) begin bad++; $display("FAIL mid_add_result got %h want f", bus.result_o); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_logic_arith;
        test_shift;
        test_illegal;
        test_back_to_back;
        test_reset_mid_shift;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
